uart_word_packer: RTL and testbench
===================================

# uart_word_packer

Parametrised packer that accumulates `WORDS` narrow beats of `IN_W` bits, typically UART RX bytes, into one `IN_W*WORDS`-bit word. It sits between the UART receiver and the command/coordinate decoders and replaces the fixed 8→40 packer. Compared with the fixed packer it adds configurable beat order, a valid/ready output handshake with overflow detection, a synchronous resync input and an optional idle-timeout flush. A completed word is presented one cycle after its last beat, with no dead cycle between words.

## Interface
- `IN_W`, 8, input beat width (≥1)
- `WORDS`, 5, beats per output word (≥2)
- `MSB_FIRST`, 1, 1: first beat lands in the top `IN_W` bits; 0: first beat lands in the bottom `IN_W` bits
- `TIMEOUT`, 1000, idle clk cycles before a partial word is flushed (used only with `PACKER_TIMEOUT_EN`; ≥1)
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `in_data` in `IN_W`: input beat
- `in_valid` in 1: one-cycle strobe; beat accepted (no backpressure)
- `sync_clr` in 1: synchronous discard of the partial word
- `out_data` out `IN_W*WORDS`: packed word
- `out_valid` out 1: word available; held until accepted
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`
- `overflow` out 1: one-cycle pulse; a completed word was dropped
- `frame_err` out 1: one-cycle pulse; a partial word was discarded by timeout or `sync_clr`

## Operation
- Beat counter `cnt`, width `$clog2(WORDS)`, range 0..`WORDS-1`. The shift register `acc` is `IN_W*(WORDS-1)` bits and holds the beats received so far.
- Beat acceptance (`in_valid`):
  - `cnt < WORDS-1`: shift the beat into `acc`; `cnt++`.
  - `cnt == WORDS-1`: build the word from `acc` and `in_data` per `MSB_FIRST`; `cnt` ← 0; the word becomes complete.
- Completed word:
  - If the output register is free (`!out_valid`, or `out_ready` this cycle): load `out_data` and set `out_valid`.
  - Otherwise: drop the new word, keep the old word, and pulse `overflow`.
- `out_valid` clears on `out_valid && out_ready` unless a new word loads in the same cycle, in which case it stays 1 with the new data.
- `sync_clr`:
  - `cnt` ← 0. If `cnt != 0`, pulse `frame_err`.
  - If `in_valid` arrives in the same cycle, that beat is stored as beat 0 and `cnt` ← 1. A word can never complete in a `sync_clr` cycle.
  - `sync_clr` does not affect `out_valid` or `out_data`.
- Reset values: `cnt` 0, `acc` 0, `out_data` 0, `out_valid` 0, `overflow` 0, `frame_err` 0. Asserting reset mid-word discards the partial word and produces no pulses.

## Timing
- Latency: last beat at cycle N → `out_valid` and `out_data` at N+1.
- Full throughput: `in_valid` every cycle gives one word every `WORDS` cycles, provided `out_ready` is held high.
- `overflow` and `frame_err` are registered and rise at N+1 relative to their cause.
- Simultaneous events resolve in this order: `rst_n` > `sync_clr` > timeout > beat acceptance.

## Configuration
- `PACKER_TIMEOUT_EN` defined:
  - An idle counter counts cycles with `cnt != 0 && !in_valid`. It clears on `in_valid`, on `sync_clr`, and whenever `cnt == 0`.
  - When it reaches `TIMEOUT`: `cnt` ← 0 and `frame_err` pulses.
  - A beat arriving in the flush cycle is stored as beat 0 (`cnt` ← 1).
- `PACKER_TIMEOUT_EN` undefined: no idle counter; a partial word persists indefinitely; `TIMEOUT` is ignored.

## Structure
- Shared package `packer_pkg`:
  - default constants `PK_IN_W = 8`, `PK_WORDS = 5`, `PK_TIMEOUT = 1000`;
  - function `pk_cnt_w(words)` returning the counter width.
- Sub-module `packer_idle_timer`: a `TIMEOUT`-cycle counter with `start`/`clear` inputs and a one-cycle `expire` output. It is instantiated only under `PACKER_TIMEOUT_EN`.

## Test plan
- **Default order, ready high:** `MSB_FIRST=1`, `out_ready=1`, beats 0x11,0x22,0x33,0x44,0x55 with gaps → `out_data`=0x1122334455, `out_valid` high for exactly one cycle, one cycle after 0x55.
- **Reversed order, back-to-back:** `MSB_FIRST=0`, beats 0x11..0x55 then 0x66..0xAA with `in_valid` continuous → words 0x5544332211 and 0xAA99887766, exactly 5 cycles apart.
- **Overflow:** `out_ready=0` while two words complete → first word held, `overflow` pulses once, `out_data` still holds the first word. Raising `out_ready` → `out_valid` drops the next cycle.
- **Timeout flush:** `PACKER_TIMEOUT_EN`, `TIMEOUT=16`; send 0xA1,0xA2 then idle 16 cycles → `frame_err` pulse. Then send 0x01..0x05 → 0x0102030405.
- **sync_clr with a beat:** `sync_clr` and `in_valid`(0x77) together at `cnt=3` → `frame_err` pulse. Then 0x78..0x7B → 0x78797A7B preceded by 0x77, i.e. 0x7778797A7B.
- **Reset mid-word:** assert `rst_n=0` after 3 beats → all outputs 0 and no pulses. The next 5 beats form a clean word.

Source files
------------

// File: rtl/packer_pkg.sv
// Shared defaults and helpers for the UART word packer.
package packer_pkg;

    localparam int unsigned PK_IN_W    = 8;
    localparam int unsigned PK_WORDS   = 5;
    localparam int unsigned PK_TIMEOUT = 1000;

    // Beat-counter width for a word of `words` beats; never narrower than 1 bit.
    function automatic int unsigned pk_cnt_w(input int unsigned words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle timer: counts cycles while start is high; expire pulses for one cycle
// once TIMEOUT idle cycles have been counted.
module packer_idle_timer
    import packer_pkg::*;
#(
    parameter int unsigned TIMEOUT = PK_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (start) begin
            count <= count + TW'(1);
        end
    end

    assign expire = (count == TW'(TIMEOUT));

endmodule

// File: rtl/uart_word_packer.sv
// Packs WORDS beats of IN_W bits into one word with valid/ready output.
// Optional idle-timeout flush of partial words: define PACKER_TIMEOUT_EN.
module uart_word_packer
    import packer_pkg::*;
#(
    parameter int unsigned IN_W      = PK_IN_W,
    parameter int unsigned WORDS     = PK_WORDS,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned TIMEOUT   = PK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    input  logic                  sync_clr,
    output logic [IN_W*WORDS-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int unsigned CW = pk_cnt_w(WORDS);
    localparam int unsigned AW = IN_W * (WORDS - 1);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic [CW-1:0]         cnt;
    logic [AW-1:0]         acc;
    logic [AW-1:0]         acc_next;
    logic [AW-1:0]         acc_first;
    logic [IN_W*WORDS-1:0] word;
    logic                  expire;

    // MSB-first shifts beats up from the bottom; LSB-first shifts down from the top.
    always_comb begin
        if (MSB_FIRST) begin
            acc_next  = (acc << IN_W) | AW'(in_data);
            acc_first = AW'(in_data);
            word      = {acc, in_data};
        end else begin
            acc_next  = (acc >> IN_W) | (AW'(in_data) << (AW - IN_W));
            acc_first = AW'(in_data) << (AW - IN_W);
            word      = {in_data, acc};
        end
    end

`ifdef PACKER_TIMEOUT_EN
    logic idle_start;
    logic idle_clear;

    assign idle_start = (cnt != '0) && !in_valid;
    assign idle_clear = in_valid || sync_clr || (cnt == '0);

    packer_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (idle_start),
        .clear  (idle_clear),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // sync_clr and timeout flush act identically; either restarts at beat 0.
            if (sync_clr || expire) begin
                if (cnt != '0) begin
                    frame_err <= 1'b1;
                end
                if (in_valid) begin
                    acc <= acc_first;
                    cnt <= CW'(1);
                end else begin
                    cnt <= '0;
                end
            end else if (in_valid) begin
                if (cnt == LAST) begin
                    cnt <= '0;
                    if (!out_valid || out_ready) begin
                        out_data  <= word;
                        out_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer: one MSB-first and one LSB-first instance
// driven by the same stimulus.
module tb_uart_word_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        sync_clr = 1'b0;
    logic        out_ready = 1'b0;

    logic [39:0] m_data, l_data;
    logic        m_valid, l_valid, m_ovf, l_ovf, m_ferr, l_ferr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_word_packer #(
        .IN_W      (8),
        .WORDS     (5),
        .MSB_FIRST (1'b1),
        .TIMEOUT   (16)
    ) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sync_clr  (sync_clr),
        .out_data  (m_data),
        .out_valid (m_valid),
        .out_ready (out_ready),
        .overflow  (m_ovf),
        .frame_err (m_ferr)
    );

    uart_word_packer #(
        .IN_W      (8),
        .WORDS     (5),
        .MSB_FIRST (1'b0),
        .TIMEOUT   (16)
    ) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sync_clr  (sync_clr),
        .out_data  (l_data),
        .out_valid (l_valid),
        .out_ready (out_ready),
        .overflow  (l_ovf),
        .frame_err (l_ferr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", m_valid); end
        n_cmp++; if (m_data !== 40'h0) begin n_bad++; $display("FAIL rst_data got %h exp 0", m_data); end
        n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b exp 0", m_ovf); end
        n_cmp++; if (m_ferr !== 1'b0) begin n_bad++; $display("FAIL rst_ferr got %b exp 0", m_ferr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_default_order();
        out_ready = 1'b1;
        send(8'h11); tick();
        send(8'h22); tick();
        send(8'h33); tick();
        send(8'h44); tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL dflt_early_valid got %b exp 0", m_valid); end
        send(8'h55);
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL dflt_valid got %b exp 1", m_valid); end
        n_cmp++; if (m_data !== 40'h1122334455) begin n_bad++; $display("FAIL dflt_msb_data got %h exp 1122334455", m_data); end
        n_cmp++; if (l_data !== 40'h5544332211) begin n_bad++; $display("FAIL dflt_lsb_data got %h exp 5544332211", l_data); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL dflt_valid_drop got %b exp 0", m_valid); end
        n_cmp++; if (l_valid !== 1'b0) begin n_bad++; $display("FAIL dflt_lsb_valid_drop got %b exp 0", l_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data  = 8'((i + 1) * 17);
            in_valid = 1'b1;
            tick();
            if (i == 4) begin
                n_cmp++; if (l_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_w1_valid got %b exp 1", l_valid); end
                n_cmp++; if (l_data !== 40'h5544332211) begin n_bad++; $display("FAIL b2b_w1_lsb got %h exp 5544332211", l_data); end
                n_cmp++; if (m_data !== 40'h1122334455) begin n_bad++; $display("FAIL b2b_w1_msb got %h exp 1122334455", m_data); end
            end else if (i > 4 && i < 9) begin
                n_cmp++; if (l_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_valid i=%0d got %b exp 0", i, l_valid); end
            end else if (i == 9) begin
                n_cmp++; if (l_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_w2_valid got %b exp 1", l_valid); end
                n_cmp++; if (l_data !== 40'hAA99887766) begin n_bad++; $display("FAIL b2b_w2_lsb got %h exp aa99887766", l_data); end
                n_cmp++; if (m_data !== 40'h66778899AA) begin n_bad++; $display("FAIL b2b_w2_msb got %h exp 66778899aa", m_data); end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data  = 8'(i + 1);
            in_valid = 1'b1;
            tick();
            if (i == 4) begin
                n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_w1_valid got %b exp 1", m_valid); end
                n_cmp++; if (m_data !== 40'h0102030405) begin n_bad++; $display("FAIL ovf_w1_data got %h exp 0102030405", m_data); end
            end else if (i > 4 && i < 9) begin
                n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early i=%0d got %b exp 0", i, m_ovf); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (m_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse got %b exp 1", m_ovf); end
        n_cmp++; if (l_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_lsb_pulse got %b exp 1", l_ovf); end
        n_cmp++; if (m_data !== 40'h0102030405) begin n_bad++; $display("FAIL ovf_hold_data got %h exp 0102030405", m_data); end
        n_cmp++; if (l_data !== 40'h0504030201) begin n_bad++; $display("FAIL ovf_hold_lsb got %h exp 0504030201", l_data); end
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_hold_valid got %b exp 1", m_valid); end
        tick();
        n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_single got %b exp 0", m_ovf); end
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_still_valid got %b exp 1", m_valid); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_accept got %b exp 0", m_valid); end
        n_cmp++; if (l_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_lsb_accept got %b exp 0", l_valid); end
    endtask

    task automatic test_sync_clr();
        out_ready = 1'b1;
        send(8'h70);
        send(8'h71);
        send(8'h72);
        sync_clr = 1'b1;
        in_data  = 8'h77;
        in_valid = 1'b1;
        tick();
        sync_clr = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (m_ferr !== 1'b1) begin n_bad++; $display("FAIL sclr_ferr got %b exp 1", m_ferr); end
        n_cmp++; if (l_ferr !== 1'b1) begin n_bad++; $display("FAIL sclr_lsb_ferr got %b exp 1", l_ferr); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL sclr_no_word got %b exp 0", m_valid); end
        tick();
        n_cmp++; if (m_ferr !== 1'b0) begin n_bad++; $display("FAIL sclr_ferr_single got %b exp 0", m_ferr); end
        send(8'h78);
        send(8'h79);
        send(8'h7A);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL sclr_early_valid got %b exp 0", m_valid); end
        send(8'h7B);
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL sclr_valid got %b exp 1", m_valid); end
        n_cmp++; if (m_data !== 40'h7778797A7B) begin n_bad++; $display("FAIL sclr_msb_data got %h exp 7778797a7b", m_data); end
        n_cmp++; if (l_data !== 40'h7B7A797877) begin n_bad++; $display("FAIL sclr_lsb_data got %h exp 7b7a797877", l_data); end
        // sync_clr with an empty partial word and a pending output word
        out_ready = 1'b0;
        sync_clr  = 1'b1;
        tick();
        sync_clr = 1'b0;
        n_cmp++; if (m_ferr !== 1'b0) begin n_bad++; $display("FAIL sclr_idle_ferr got %b exp 0", m_ferr); end
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL sclr_keep_valid got %b exp 1", m_valid); end
        n_cmp++; if (m_data !== 40'h7778797A7B) begin n_bad++; $display("FAIL sclr_keep_data got %h exp 7778797a7b", m_data); end
        out_ready = 1'b1;
        tick();
    endtask

`ifdef PACKER_TIMEOUT_EN
    task automatic test_timeout();
        out_ready = 1'b1;
        send(8'hA1);
        send(8'hA2);
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++; if (m_ferr !== 1'b0) begin n_bad++; $display("FAIL tmo_early idle=%0d got %b exp 0", i + 1, m_ferr); end
        end
        tick();
        n_cmp++; if (m_ferr !== 1'b1) begin n_bad++; $display("FAIL tmo_ferr got %b exp 1", m_ferr); end
        n_cmp++; if (l_ferr !== 1'b1) begin n_bad++; $display("FAIL tmo_lsb_ferr got %b exp 1", l_ferr); end
        tick();
        n_cmp++; if (m_ferr !== 1'b0) begin n_bad++; $display("FAIL tmo_ferr_single got %b exp 0", m_ferr); end
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'h05);
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL tmo_valid got %b exp 1", m_valid); end
        n_cmp++; if (m_data !== 40'h0102030405) begin n_bad++; $display("FAIL tmo_msb_data got %h exp 0102030405", m_data); end
        n_cmp++; if (l_data !== 40'h0504030201) begin n_bad++; $display("FAIL tmo_lsb_data got %h exp 0504030201", l_data); end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4); send(8'hC5);
        n_cmp++; if (m_data !== 40'hC1C2C3C4C5) begin n_bad++; $display("FAIL rmid_pre_data got %h exp c1c2c3c4c5", m_data); end
        send(8'hD1); send(8'hD2); send(8'hD3);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b exp 0", m_valid); end
        n_cmp++; if (m_data !== 40'h0) begin n_bad++; $display("FAIL rmid_data got %h exp 0", m_data); end
        n_cmp++; if (l_data !== 40'h0) begin n_bad++; $display("FAIL rmid_lsb_data got %h exp 0", l_data); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (m_ferr !== 1'b0) begin n_bad++; $display("FAIL rmid_ferr got %b exp 0", m_ferr); end
        n_cmp++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf got %b exp 0", m_ovf); end
        out_ready = 1'b1;
        send(8'hE1); send(8'hE2); send(8'hE3); send(8'hE4);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_early_valid got %b exp 0", m_valid); end
        send(8'hE5);
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_post_valid got %b exp 1", m_valid); end
        n_cmp++; if (m_data !== 40'hE1E2E3E4E5) begin n_bad++; $display("FAIL rmid_msb_data got %h exp e1e2e3e4e5", m_data); end
        n_cmp++; if (l_data !== 40'hE5E4E3E2E1) begin n_bad++; $display("FAIL rmid_lsb_data got %h exp e5e4e3e2e1", l_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_default_order();
        test_back_to_back();
        test_overflow();
        test_sync_clr();
`ifdef PACKER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
